link_arbiter: RTL and testbench
===============================

Name: link_arbiter

Overview:
- Shares one outgoing inter-router link (east or west) between two FIFO sources:
  - the local-injection buffer, fed by the core-side splitter;
  - the forward buffer, holding packets passing through from the neighbouring router.
- Pops the chosen source and registers the packet onto the downstream FIFO write port, throttled by downstream full/almost_full.
- Forward traffic has priority; MAX_BURST guarantees local traffic a bounded wait.

Parameters:
- PACKET_WIDTH, 30: packet width in bits.
- MAX_BURST, 4: maximum consecutive grants to one source while the other source is requesting (>=1).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- en  in  1  arbitration enable; 0 = no new grants (drain/pause)
- local_dout  in  PACKET_WIDTH  head of local buffer (first-word fall-through, valid when !local_empty)
- local_empty  in  1  local buffer empty
- local_ren  out  1  pop local buffer this cycle
- fwd_dout  in  PACKET_WIDTH  head of forward buffer (FWFT)
- fwd_empty  in  1  forward buffer empty
- fwd_ren  out  1  pop forward buffer this cycle
- out_data  out  PACKET_WIDTH  registered packet to downstream FIFO
- out_wen  out  1  registered write strobe to downstream FIFO
- out_src  out  1  source of current out_data: 1 = forward, 0 = local
- out_full  in  1  downstream FIFO full
- out_almost_full  in  1  downstream FIFO has exactly one free slot

Interface decision: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst=0, immediate): out_wen=0, out_data=0, out_src=0, owner=NONE, burst_cnt=0. local_ren and fwd_ren are forced 0 while rst=0.
- Signal definitions:
  - req_l = !local_empty; req_f = !fwd_empty.
  - can_issue = en && !out_full && !(out_wen && out_almost_full). This covers the one write already in flight.
- State: owner in {NONE, LOCAL, FWD}; burst_cnt, width clog2(MAX_BURST) (min 1), counts grants to the current owner minus one.
- Grant selection, evaluated combinationally each cycle when can_issue:
  - owner requesting and (burst_cnt+1 < MAX_BURST or other source not requesting) -> keep owner.
  - otherwise, other source requesting -> switch to it.
  - otherwise, exactly one source requesting (owner NONE or owner idle) -> that source.
  - both requesting with owner NONE -> FWD.
  - none requesting -> no grant.
- On a grant:
  - the granted source's ren is 1 in the same cycle (Mealy); the other ren is 0.
  - Next edge: out_data <= granted dout, out_src <= granted id, out_wen <= 1.
  - Next edge: owner <= granted source; burst_cnt <= (same owner) ? min(burst_cnt+1, MAX_BURST-1) : 0.
- No grant with can_issue=1 (no requests): out_wen <= 0, owner <= NONE, burst_cnt <= 0.
- can_issue=0: both ren 0, out_wen <= 0; owner, burst_cnt, out_data and out_src hold.
- Latency: source pop -> out_wen one cycle later. Throughput: 1 packet/cycle while downstream is not almost full. With almost_full=1, writes alternate at best every other cycle.
- Never assert ren on an empty source. Never assert both ren in one cycle.
- MAX_BURST=1: strict alternation whenever both sources request.
- en deasserted mid-burst: the in-flight write completes; the burst resumes with preserved owner and burst_cnt when en returns.
- Reset mid-operation: a packet already popped but not yet written is discarded (accepted loss; upstream is reset with the same rst).

Decomposition:
- Shared router package: owner encoding (OWN_NONE=2'd0, OWN_LOCAL=2'd1, OWN_FWD=2'd2) and the source-id constants used by out_src.
- One natural sub-module, rr_burst_grant: pure grant logic plus the owner/burst_cnt registers. The top level holds the output register and the throttle.

Test Plan (MAX_BURST=4):
- Reset with both sources non-empty, rst=0 -> both ren 0, out_wen 0; after release with 10 FWD + 10 LOCAL queued, first grant is FWD.
- Both sources continuously non-empty, downstream never full -> out_src sequence FWD x4, LOCAL x4, FWD x4...; out_wen high every cycle after the first; packet order within each source preserved.
- Only LOCAL non-empty with 6 packets -> 6 consecutive grants, no forced switch; out_data matches pushed values in order.
- Downstream out_almost_full=1 held, single source with 3 packets -> writes on alternate cycles, out_full never overflowed (scoreboard counts exactly 3 writes).
- out_full=1 for 5 cycles mid-stream -> no ren and out_wen=0 throughout; owner and burst_cnt preserved; stream resumes with the same owner.
- rst pulsed low asynchronously between clock edges during a burst -> outputs clear immediately; no ren until release; arbitration restarts from owner NONE.

Source files
------------

// File: rtl/link_arbiter_pkg.sv
// Shared router definitions: link owner encoding, source ids and sizing helpers.
package link_arbiter_pkg;

    // Current holder of the outgoing link.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_LOCAL = 2'd1,
        OWN_FWD   = 2'd2
    } owner_e;

    // Values driven on out_src to tag where a packet came from.
    localparam logic SRC_LOCAL = 1'b0;
    localparam logic SRC_FWD   = 1'b1;

    // Width of the burst counter; at least one bit even when MAX_BURST is 1.
    function automatic int burst_cnt_width(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/rr_burst_grant.sv
// Grant selection between local and forward sources with bounded forward bursts.
// Holds the owner and burst counter; the caller supplies the issue qualifier.
module rr_burst_grant
    import link_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic can_issue,
    input  logic req_l,
    input  logic req_f,
    output logic grant_l,
    output logic grant_f
);

    localparam int                CNT_W   = burst_cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_BURST - 1);

    owner_e             owner_q;
    owner_e             grant;
    logic [CNT_W-1:0]   burst_cnt;
    logic               owner_req;
    logic               other_req;
    logic               burst_open;

    // Whether the current owner and the other source want the link.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise an unassigned path infers a latch.
        owner_req = 1'b0;
        other_req = 1'b0;
        unique case (owner_q)
            OWN_LOCAL: begin
                owner_req = req_l;
                other_req = req_f;
            end
            OWN_FWD: begin
                owner_req = req_f;
                other_req = req_l;
            end
            default: ;
        endcase
    end

    // The owner may take another grant while its burst has room left.
    assign burst_open = (burst_cnt < CNT_MAX);

    // Choose this cycle's grant: keep the owner, hand over, or pick fresh.
    always_comb begin
        grant = OWN_NONE;
        if (can_issue) begin
            if (owner_req && (burst_open || !other_req)) begin
                grant = owner_q;
            end else if (other_req) begin
                grant = (owner_q == OWN_LOCAL) ? OWN_FWD : OWN_LOCAL;
            end else if (req_f) begin
                // Reached with no owner: forward wins ties and lone requests.
                grant = OWN_FWD;
            end else if (req_l) begin
                grant = OWN_LOCAL;
            end
        end
    end

    assign grant_l = (grant == OWN_LOCAL);
    assign grant_f = (grant == OWN_FWD);

    // Track who owns the link and how many back-to-back grants it has had.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q   <= OWN_NONE;
            burst_cnt <= '0;
        end else if (can_issue) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            if (grant == OWN_NONE) begin
                owner_q   <= OWN_NONE;
                burst_cnt <= '0;
            end else begin
                owner_q <= grant;
                if (grant == owner_q) begin
                    burst_cnt <= (burst_cnt == CNT_MAX) ? CNT_MAX : burst_cnt + 1'b1;
                end else begin
                    burst_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/link_arbiter.sv
// Outgoing link arbiter: pops local or forward FIFO and registers the packet
// onto the downstream write port, throttled by downstream full/almost_full.
module link_arbiter
    import link_arbiter_pkg::*;
#(
    parameter int PACKET_WIDTH = 30,
    parameter int MAX_BURST    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [PACKET_WIDTH-1:0] local_dout,
    input  logic                    local_empty,
    output logic                    local_ren,
    input  logic [PACKET_WIDTH-1:0] fwd_dout,
    input  logic                    fwd_empty,
    output logic                    fwd_ren,
    output logic [PACKET_WIDTH-1:0] out_data,
    output logic                    out_wen,
    output logic                    out_src,
    input  logic                    out_full,
    input  logic                    out_almost_full
);

    logic can_issue;
    logic grant_l;
    logic grant_f;

    // The registered write still in flight takes the last free slot when
    // downstream reports almost full, so hold off one cycle in that case.
    assign can_issue = en && !out_full && !(out_wen && out_almost_full);

    rr_burst_grant #(
        .MAX_BURST (MAX_BURST)
    ) u_grant (
        .clk       (clk),
        .rst       (rst),
        .can_issue (can_issue),
        .req_l     (!local_empty),
        .req_f     (!fwd_empty),
        .grant_l   (grant_l),
        .grant_f   (grant_f)
    );

    // Pops follow the grant in the same cycle and are suppressed during reset.
    assign local_ren = rst && grant_l;
    assign fwd_ren   = rst && grant_f;

    // Register the granted packet onto the downstream write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data <= '0;
            out_src  <= SRC_LOCAL;
            out_wen  <= 1'b0;
        end else if (can_issue && (grant_l || grant_f)) begin
            out_data <= grant_f ? fwd_dout : local_dout;
            out_src  <= grant_f ? SRC_FWD : SRC_LOCAL;
            out_wen  <= 1'b1;
        end else begin
            out_wen <= 1'b0;
        end
    end

endmodule

// File: tb/tb_link_arbiter.sv
// Self-checking bench for link_arbiter: directed scenarios plus a randomized
// phase, all compared against a queue-based behavioural model.
module tb_link_arbiter;

    localparam int PW = 30;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [PW-1:0] local_dout;
    logic          local_empty;
    logic          local_ren;
    logic [PW-1:0] fwd_dout;
    logic          fwd_empty;
    logic          fwd_ren;
    logic [PW-1:0] out_data;
    logic          out_wen;
    logic          out_src;
    logic          out_full;
    logic          out_almost_full;

    int vectors     = 0;
    int miscompares = 0;

    // Source FIFO contents; element 0 is the head.
    logic [PW-1:0] lq[$];
    logic [PW-1:0] fq[$];

    // Reference model state: owner 0=none 1=local 2=fwd, run = grants so far.
    int            m_owner = 0;
    int            m_run   = 0;
    logic          exp_wen = 1'b0;
    logic          exp_src = 1'b0;
    logic [PW-1:0] exp_data = '0;

    int   writes = 0;
    int   b2b    = 0;
    logic prev_wen = 1'b0;
    logic src_log[$];

    always #5 clk = ~clk;

    link_arbiter #(
        .PACKET_WIDTH (PW),
        .MAX_BURST    (MB)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .local_dout      (local_dout),
        .local_empty     (local_empty),
        .local_ren       (local_ren),
        .fwd_dout        (fwd_dout),
        .fwd_empty       (fwd_empty),
        .fwd_ren         (fwd_ren),
        .out_data        (out_data),
        .out_wen         (out_wen),
        .out_src         (out_src),
        .out_full        (out_full),
        .out_almost_full (out_almost_full)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present the FIFO heads to the DUT.
    task automatic drive_src();
        local_empty = (lq.size() == 0);
        fwd_empty   = (fq.size() == 0);
        local_dout  = (lq.size() != 0) ? lq[0] : '0;
        fwd_dout    = (fq.size() != 0) ? fq[0] : '0;
    endtask

    function automatic bit model_can();
        return rst && en && !out_full && !(exp_wen && out_almost_full);
    endfunction

    // Arbitration rule from the source's point of view.
    function automatic int model_grant();
        bit rl, rf, own_req, oth_req;
        rl = (lq.size() != 0);
        rf = (fq.size() != 0);
        if (!model_can()) return 0;
        own_req = (m_owner == 1 && rl) || (m_owner == 2 && rf);
        oth_req = (m_owner == 1 && rf) || (m_owner == 2 && rl);
        if (own_req && (m_run < MB || !oth_req)) return m_owner;
        if (oth_req) return 3 - m_owner;
        if (rf) return 2;
        if (rl) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_owner  = 0;
        m_run    = 0;
        exp_wen  = 1'b0;
        exp_src  = 1'b0;
        exp_data = '0;
    endtask

    // One clock cycle: check pops before the edge, outputs after it.
    task automatic step();
        int g;
        bit can, rst_pre;
        @(negedge clk);
        drive_src();
        #1;
        g       = model_grant();
        can     = model_can();
        rst_pre = rst;
        check("local_ren", {31'd0, local_ren}, {31'd0, g == 1});
        check("fwd_ren",   {31'd0, fwd_ren},   {31'd0, g == 2});
        @(posedge clk);
        #1;
        if (!rst_pre || !rst) begin
            model_reset();
        end else if (can) begin
            if (g != 0) begin
                if (g == 2) exp_data = fq.pop_front();
                else        exp_data = lq.pop_front();
                exp_src = (g == 2);
                exp_wen = 1'b1;
                m_run   = (g == m_owner) ? ((m_run < MB) ? m_run + 1 : MB) : 1;
                m_owner = g;
            end else begin
                exp_wen = 1'b0;
                m_owner = 0;
                m_run   = 0;
            end
        end else begin
            exp_wen = 1'b0;
        end
        drive_src();
        check("out_wen",  {31'd0, out_wen}, {31'd0, exp_wen});
        check("out_data", {2'd0, out_data}, {2'd0, exp_data});
        check("out_src",  {31'd0, out_src}, {31'd0, exp_src});
        if (out_wen === 1'b1) begin
            writes++;
            src_log.push_back(out_src);
            if (prev_wen) b2b++;
        end
        prev_wen = out_wen;
    endtask

    // Run until both sources are empty and the last write has gone out.
    task automatic drain(input int budget);
        for (int i = 0; i < budget && (lq.size() != 0 || fq.size() != 0 || exp_wen); i++) begin
            step();
        end
        check("drain_left", lq.size() + fq.size(), 0);
    endtask

    task automatic load(input int n_local, input int n_fwd);
        for (int i = 0; i < n_local; i++) lq.push_back(PW'($urandom));
        for (int i = 0; i < n_fwd; i++)   fq.push_back(PW'($urandom));
    endtask

    initial begin
        #100000;
        miscompares++;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b0;
        en              = 1'b1;
        out_full        = 1'b0;
        out_almost_full = 1'b0;
        load(10, 10);
        drive_src();

        // Reset held with both sources non-empty.
        #13;
        check("rst_local_ren", {31'd0, local_ren}, 0);
        check("rst_fwd_ren",   {31'd0, fwd_ren},   0);
        check("rst_out_wen",   {31'd0, out_wen},   0);
        check("rst_out_data",  {2'd0, out_data},   0);
        #5;
        rst = 1'b1;

        // Both sources busy: forward first, then bursts of MB alternating.
        step();
        check("first_grant_src", {31'd0, out_src}, 1);
        drain(60);
        check("both_writes", src_log.size(), 20);
        for (int i = 0; i < 16; i++) begin
            check("burst_pattern", {31'd0, src_log[i]}, {31'd0, ((i / MB) % 2) == 0});
        end

        // Local only: no forced switch, all six go out back to back.
        src_log.delete();
        writes = 0;
        load(6, 0);
        drain(20);
        check("local_writes", writes, 6);
        for (int i = 0; i < src_log.size(); i++) check("local_src", {31'd0, src_log[i]}, 0);

        // Almost full held: writes alternate, exactly three land.
        writes          = 0;
        b2b             = 0;
        prev_wen        = 1'b0;
        out_almost_full = 1'b1;
        load(3, 0);
        for (int i = 0; i < 8; i++) step();
        check("af_writes", writes, 3);
        check("af_back_to_back", b2b, 0);
        out_almost_full = 1'b0;
        step();

        // Full mid-stream, then an en pause: owner survives both.
        load(10, 10);
        step();
        step();
        check("pre_full_src", {31'd0, out_src}, 1);
        out_full = 1'b1;
        for (int i = 0; i < 5; i++) step();
        out_full = 1'b0;
        step();
        check("post_full_src", {31'd0, out_src}, 1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) step();
        en = 1'b1;
        drain(60);

        // Asynchronous reset between edges during a burst.
        load(10, 10);
        step();
        step();
        step();
        #3;
        rst = 1'b0;
        #1;
        check("arst_out_wen",   {31'd0, out_wen},   0);
        check("arst_out_data",  {2'd0, out_data},   0);
        check("arst_out_src",   {31'd0, out_src},   0);
        check("arst_local_ren", {31'd0, local_ren}, 0);
        check("arst_fwd_ren",   {31'd0, fwd_ren},   0);
        model_reset();
        step();
        step();
        rst = 1'b1;
        step();
        check("restart_src", {31'd0, out_src}, 1);
        drain(60);

        // Randomized traffic and throttling.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 40) lq.push_back(PW'($urandom));
            if ($urandom_range(0, 99) < 40) fq.push_back(PW'($urandom));
            en              = ($urandom_range(0, 99) < 90);
            out_full        = ($urandom_range(0, 99) < 10);
            out_almost_full = ($urandom_range(0, 99) < 20);
            step();
        end
        en              = 1'b1;
        out_full        = 1'b0;
        out_almost_full = 1'b0;
        drain(400);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
